// File: rtl/buzzer_decoder.sv
`default_nettype none
// ============================================================================
// buzzer_decoder : recovers the one-hot note selector from the buzzer pulse
// Revision: 1.0
// ============================================================================
module buzzer_decoder #(
  parameter int CONFIRM = 3,
  parameter int TIMEOUT = 12
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pulso,
  output logic [3:0] seletor,
  output logic       valido,
  output logic       mudou,
  output logic       erro,
  output logic [4:0] periodo
);

  localparam logic [4:0] c_timeout    = 5'(TIMEOUT);
  localparam logic [4:0] c_timeout_m1 = 5'(TIMEOUT - 1);
  localparam logic [2:0] c_confirm    = 3'(CONFIRM);

  typedef enum logic [1:0] {
    SILENCIO = 2'd0,
    MEDINDO  = 2'd1,
    TRAVADO  = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_pulso_ant;
  logic [4:0] r_cnt;
  logic [3:0] r_candidate;
  logic [2:0] r_acertos;

  logic       w_borda;
  logic [3:0] w_class;
  logic       w_valid;
  logic       w_timeout;
  logic [2:0] w_hits;

  function automatic logic [3:0] classify(input logic [4:0] p);
    case (p)
      5'd2:    classify = 4'b1000;
      5'd3:    classify = 4'b0100;
      5'd4:    classify = 4'b0010;
      5'd8:    classify = 4'b0001;
      default: classify = 4'b0000;
    endcase
  endfunction

  // r_cnt still holds the pre-reload interval during the edge cycle
  always_comb begin
    w_borda   = pulso & ~r_pulso_ant;
    w_class   = classify(r_cnt);
    w_valid   = |w_class;
    w_timeout = ~w_borda & (r_cnt == c_timeout_m1);
    w_hits    = (w_class == r_candidate) ? (r_acertos + 3'd1) : 3'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= SILENCIO;
      r_pulso_ant <= 1'b0;
      r_cnt       <= c_timeout;
      r_candidate <= 4'b0000;
      r_acertos   <= 3'd0;
      seletor     <= 4'b0000;
      valido      <= 1'b0;
      mudou       <= 1'b0;
      erro        <= 1'b0;
      periodo     <= 5'd0;
    end else begin
      r_pulso_ant <= pulso;
      mudou       <= 1'b0;
      erro        <= 1'b0;

      if (w_borda)
        r_cnt <= 5'd1;
      else if (r_cnt != c_timeout)
        r_cnt <= r_cnt + 5'd1;

      if (w_borda) begin
        case (r_state)
          SILENCIO: begin
            r_state   <= MEDINDO;
            r_acertos <= 3'd0;
          end
          MEDINDO, TRAVADO: begin
            periodo <= r_cnt;
            if (!w_valid) begin
              erro      <= 1'b1;
              r_acertos <= 3'd0;
              r_state   <= MEDINDO;
            end else if (!(r_state == TRAVADO && w_class == seletor)) begin
              // seletor keeps its old value until the new class confirms
              r_candidate <= w_class;
              r_acertos   <= w_hits;
              if (w_hits >= c_confirm) begin
                r_state <= TRAVADO;
                seletor <= w_class;
                valido  <= 1'b1;
                mudou   <= (w_class != seletor);
              end else begin
                r_state <= MEDINDO;
              end
            end
          end
          default: r_state <= SILENCIO;
        endcase
      end else if (w_timeout) begin
        r_state <= SILENCIO;
        seletor <= 4'b0000;
        valido  <= 1'b0;
        mudou   <= |seletor;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_buzzer_decoder.sv
`default_nettype none
// ============================================================================
// tb_buzzer_decoder : directed self-checking bench for buzzer_decoder
// Revision: 1.0
// ============================================================================
module tb_buzzer_decoder;

  logic       clock;
  logic       reset;
  logic       pulso;
  logic [3:0] seletor;
  logic       valido;
  logic       mudou;
  logic       erro;
  logic [4:0] periodo;

  int checks = 0;
  int errors = 0;

  buzzer_decoder #(
    .CONFIRM(3),
    .TIMEOUT(12)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .pulso  (pulso),
    .seletor(seletor),
    .valido (valido),
    .mudou  (mudou),
    .erro   (erro),
    .periodo(periodo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // drive one cycle of pulso; returns 1 time unit after the capturing edge
  task automatic step(input logic p);
    pulso = p;
    @(posedge clock);
    #1;
  endtask

  // edge exactly p cycles after the previous edge step
  task automatic edge_after(input int p);
    repeat (p - 1) step(1'b0);
    step(1'b1);
  endtask

  initial begin
    reset = 1'b0;
    pulso = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_sel", 32'(seletor), 32'h0);
    chk("rst_val", 32'(valido), 32'h0);
    chk("rst_mud", 32'(mudou), 32'h0);
    chk("rst_err", 32'(erro), 32'h0);
    chk("rst_per", 32'(periodo), 32'h0);
    reset = 1'b1;

    // period 2: first edge only starts measuring, lock after the 4th edge
    step(1'b1);
    chk("p2_e1_sel", 32'(seletor), 32'h0);
    edge_after(2);
    chk("p2_e2_per", 32'(periodo), 32'd2);
    chk("p2_e2_sel", 32'(seletor), 32'h0);
    edge_after(2);
    chk("p2_e3_val", 32'(valido), 32'h0);
    edge_after(2);
    chk("p2_lock_sel", 32'(seletor), 32'h8);
    chk("p2_lock_val", 32'(valido), 32'h1);
    chk("p2_lock_mud", 32'(mudou), 32'h1);
    step(1'b0);
    chk("p2_mud_clr", 32'(mudou), 32'h0);

    // switch to period 8 (one zero already spent)
    edge_after(7);
    chk("p8_e1_per", 32'(periodo), 32'd8);
    chk("p8_e1_sel", 32'(seletor), 32'h8);
    edge_after(8);
    edge_after(8);
    chk("p8_lock_sel", 32'(seletor), 32'h1);
    chk("p8_lock_mud", 32'(mudou), 32'h1);
    edge_after(8);
    chk("p8_hold_mud", 32'(mudou), 32'h0);
    chk("p8_hold_per", 32'(periodo), 32'd8);

    // period 3 with no gap
    edge_after(3);
    chk("p3_e1_per", 32'(periodo), 32'd3);
    chk("p3_e1_sel", 32'(seletor), 32'h1);
    chk("p3_e1_val", 32'(valido), 32'h1);
    edge_after(3);
    chk("p3_e2_sel", 32'(seletor), 32'h1);
    edge_after(3);
    chk("p3_lock_sel", 32'(seletor), 32'h4);
    chk("p3_lock_mud", 32'(mudou), 32'h1);
    step(1'b0);
    chk("p3_mud_clr", 32'(mudou), 32'h0);

    // lock at period 4, then silence
    edge_after(3);
    edge_after(4);
    edge_after(4);
    chk("p4_lock_sel", 32'(seletor), 32'h2);
    chk("p4_lock_mud", 32'(mudou), 32'h1);
    repeat (10) step(1'b0);
    chk("to_pre_sel", 32'(seletor), 32'h2);
    chk("to_pre_val", 32'(valido), 32'h1);
    step(1'b0);
    chk("to_sel", 32'(seletor), 32'h0);
    chk("to_val", 32'(valido), 32'h0);
    chk("to_mud", 32'(mudou), 32'h1);
    chk("to_per", 32'(periodo), 32'd4);
    step(1'b0);
    chk("to_mud_clr", 32'(mudou), 32'h0);

    // period 5 from silence: erro on every edge after the first
    step(1'b1);
    chk("p5_e1_err", 32'(erro), 32'h0);
    edge_after(5);
    chk("p5_e2_err", 32'(erro), 32'h1);
    chk("p5_e2_per", 32'(periodo), 32'd5);
    chk("p5_e2_sel", 32'(seletor), 32'h0);
    step(1'b0);
    chk("p5_err_clr", 32'(erro), 32'h0);
    edge_after(4);
    chk("p5_e3_err", 32'(erro), 32'h1);
    chk("p5_e3_val", 32'(valido), 32'h0);
    step(1'b0);
    chk("p5_err_clr2", 32'(erro), 32'h0);

    // period 2 lock, one spacing of 6, re-confirm silently
    edge_after(1);
    chk("p2b_e1_sel", 32'(seletor), 32'h0);
    edge_after(2);
    edge_after(2);
    chk("p2b_lock_sel", 32'(seletor), 32'h8);
    chk("p2b_lock_mud", 32'(mudou), 32'h1);
    edge_after(6);
    chk("gap_err", 32'(erro), 32'h1);
    chk("gap_per", 32'(periodo), 32'd6);
    chk("gap_sel", 32'(seletor), 32'h8);
    chk("gap_val", 32'(valido), 32'h1);
    edge_after(2);
    chk("gap_r1_err", 32'(erro), 32'h0);
    edge_after(2);
    edge_after(2);
    chk("gap_r3_sel", 32'(seletor), 32'h8);
    chk("gap_r3_mud", 32'(mudou), 32'h0);
    chk("gap_r3_val", 32'(valido), 32'h1);

    // lock at 0100, then asynchronous reset pulse
    edge_after(3);
    edge_after(3);
    edge_after(3);
    chk("p3b_lock_sel", 32'(seletor), 32'h4);
    #2;
    reset = 1'b0;
    pulso = 1'b0;
    #1;
    chk("arst_sel", 32'(seletor), 32'h0);
    chk("arst_val", 32'(valido), 32'h0);
    chk("arst_per", 32'(periodo), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    step(1'b1);
    edge_after(3);
    edge_after(3);
    chk("relock_pre_sel", 32'(seletor), 32'h0);
    edge_after(3);
    chk("relock_sel", 32'(seletor), 32'h4);
    chk("relock_val", 32'(valido), 32'h1);
    chk("relock_mud", 32'(mudou), 32'h1);
    chk("relock_per", 32'(periodo), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/buzzer_decoder.md
Name: buzzer_decoder

Overview:
- Receive end of the buzzer tone link: takes the single-bit tone pulse stream produced by the buzzer block and recovers the one-hot note selector that generated it.
- Measures the clock-cycle interval between rising edges of the pulse, classifies it as 1/2, 1/3, 1/4 or 1/8 clock, and reports a selector only after CONFIRM consecutive matching periods.
- Used by the self-check/readback path and by the game logic to confirm which note is actually sounding.

Parameters:
- CONFIRM, 3, consecutive equal-class periods required before a selector is reported (legal range 1..7).
- TIMEOUT, 12, cycles without a rising edge before the input is declared silent (legal range 9..31; must exceed 8).

Ports:
- clock  in  1  system clock; pulso is synchronous to it.
- reset  in  1  asynchronous, active-low reset; all state clears while low.
- pulso  in  1  tone pulse from buzzer; 0 when not playing.
- seletor  out  4  recovered one-hot note: 0001=1/8, 0010=1/4, 0100=1/3, 1000=1/2 clock; 0000 when silent or not yet confirmed.
- valido  out  1  high while seletor holds a confirmed note.
- mudou  out  1  one-cycle pulse whenever seletor changes value, including to 0000.
- erro  out  1  one-cycle pulse when a measured period is not 2, 3, 4 or 8.
- periodo  out  5  last measured period in cycles, saturates at TIMEOUT.

Behaviour:
- Reset (reset=0): seletor=0000, valido=0, mudou=0, erro=0, periodo=0, state SILENCIO, counter=TIMEOUT, pulso_ant=0, candidate=0000, acertos=0.
- Edge detect: borda = pulso & ~pulso_ant (pulso_ant registered every cycle). No extra synchroniser.
- Interval counter cnt (5 bit): on borda, cnt<=1; otherwise cnt<=cnt+1 saturating at TIMEOUT. Period captured on borda is the cnt value before reload, so edges at t and t+P yield P.
- Classification of P: 2->1000, 3->0100, 4->0010, 8->0001, any other -> invalid.
- States:
  - SILENCIO: seletor=0000, valido=0. First borda -> MEDINDO with acertos=0 and no period captured (periodo unchanged).
  - MEDINDO: on each borda, periodo<=P. If P is valid and class==candidate, acertos++. If P is valid and class!=candidate, candidate<=class and acertos<=1. If P is invalid, erro=1 for one cycle and acertos<=0. When acertos reaches CONFIRM -> TRAVADO; seletor<=candidate and valido<=1, registered the cycle after the confirming edge. mudou=1 in that same cycle only if the value differs from the previous seletor.
  - TRAVADO: on borda with class==seletor, stay in TRAVADO (periodo updates). Different valid class -> MEDINDO with candidate=class and acertos=1. Invalid class -> MEDINDO with acertos=0 and erro pulse. In both cases seletor/valido hold their old value until the new class is confirmed.
- Timeout: in any state, cnt reaching TIMEOUT with no borda -> SILENCIO. seletor<=0000, valido<=0, and mudou=1 if seletor was nonzero. Same-cycle borda takes priority over timeout.
- CONFIRM=1: the first measured valid period locks immediately.
- Output latency: seletor is valid exactly 1 cycle after the CONFIRM-th matching edge. The first edge after silence only starts the measurement.
- Reset asserted mid-operation clears everything immediately. After release, the first edge is treated as the first edge after silence.
- mudou and erro are never high for more than one consecutive cycle per event.

Test Plan:
- Reset, then pulso high 1 cycle every 2 cycles from t0 (edges t0, t0+2, t0+4, t0+6) -> seletor=1000, valido=1, mudou=1 at t0+7. Before that, seletor=0000.
- Period 8 stream, then switch to period 3 without a gap -> seletor stays 0001 until the 3rd period-3 edge. It then becomes 0100 one cycle later with a single mudou pulse; periodo reads 8 then 3.
- Lock at period 4, then hold pulso=0 -> exactly TIMEOUT=12 cycles after the last edge, seletor=0000, valido=0, mudou=1 for one cycle.
- Edges spaced 5 cycles apart -> erro pulses on each edge after the first, periodo=5, seletor stays 0000, valido never rises.
- Period 2 stream with one spacing of 6 inserted after lock -> erro pulse, seletor holds 1000. It re-confirms after 3 further period-2 edges with no mudou.
- Assert reset low for 1 cycle while locked at 0100 -> all outputs 0 asynchronously. Re-lock requires the first edge plus 3 matching periods.
